// File: rtl/trng_arbiter.sv
// Round-robin front end sharing one TRNG among N_REQ clients: packs TRNG_WIDTH-bit
// chunks into 32-bit words and runs a repetition-count health test on every chunk.
module trng_arbiter #(
  parameter int TRNG_WIDTH = 4,
  parameter int N_REQ      = 2,
  parameter int REP_LIMIT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      cli_req,
  output logic [N_REQ-1:0]      cli_ack,
  output logic [31:0]           cli_rdata,
  output logic                  trng_req,
  input  logic                  trng_valid,
  input  logic [TRNG_WIDTH-1:0] trng_word,
  output logic                  health_fail,
  input  logic                  health_clr,
  output logic                  busy
);

  localparam int NCHUNK = 32 / TRNG_WIDTH;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]       REP_MAX  = 8'(REP_LIMIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DELIVER, HALT} state_t;

  state_t                state, state_d;
  logic [IDX_W-1:0]      grant, grant_d;
  logic [IDX_W-1:0]      rr, rr_d;
  logic [CNT_W-1:0]      count, count_d;
  logic [31:0]           acc, acc_d;
  logic [7:0]            run_len, run_len_d;
  logic [TRNG_WIDTH-1:0] last_chunk, last_chunk_d;
  logic                  hist, hist_d;
  logic                  trng_req_d;
  logic [N_REQ-1:0]      ack_d;
  logic [31:0]           rdata_d;
  logic                  fail_d;

  logic [IDX_W-1:0]      pick;
  logic [31:0]           acc_shift;
  logic [7:0]            run_next;

  assign busy      = (state != IDLE);
  assign acc_shift = (acc << TRNG_WIDTH) | 32'(trng_word);

  // Repeat runs continue across word boundaries; only reset or a clear breaks history.
  assign run_next = (hist && trng_word == last_chunk)
                  ? ((run_len >= REP_MAX) ? REP_MAX : run_len + 8'd1)
                  : 8'd1;

  // First requesting client at or after rr, scanning cyclically.
  always_comb begin : arb
    logic found;
    logic [IDX_W-1:0] idx;
    pick  = rr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IDX_W'((int'(rr) + i) % N_REQ);
      if (!found && cli_req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state;
    grant_d      = grant;
    rr_d         = rr;
    count_d      = count;
    acc_d        = acc;
    run_len_d    = run_len;
    last_chunk_d = last_chunk;
    hist_d       = hist;
    trng_req_d   = 1'b0;
    ack_d        = '0;
    rdata_d      = cli_rdata;
    fail_d       = health_fail;

    unique case (state)
      IDLE: begin
        if (|cli_req) begin
          grant_d    = pick;
          count_d    = '0;
          trng_req_d = 1'b1;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        trng_req_d = 1'b1;
        if (trng_req && trng_valid) begin
          acc_d        = acc_shift;
          count_d      = count + CNT_W'(1);
          run_len_d    = run_next;
          last_chunk_d = trng_word;
          hist_d       = 1'b1;
          // A failing chunk wins over word completion: the partial word is dropped.
          if (run_next == REP_MAX) begin
            fail_d     = 1'b1;
            trng_req_d = 1'b0;
            state_d    = HALT;
          end else if (count == LAST_CNT) begin
            trng_req_d = 1'b0;
            ack_d      = N_REQ'(1) << grant;
            rdata_d    = acc_shift;
            state_d    = DELIVER;
          end
        end
      end
      DELIVER: begin
        rr_d    = (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
        state_d = IDLE;
      end
      HALT: begin
        if (health_clr) begin
          fail_d    = 1'b0;
          run_len_d = '0;
          hist_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      rr          <= '0;
      count       <= '0;
      acc         <= '0;
      run_len     <= '0;
      last_chunk  <= '0;
      hist        <= 1'b0;
      trng_req    <= 1'b0;
      cli_ack     <= '0;
      cli_rdata   <= '0;
      health_fail <= 1'b0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      rr          <= rr_d;
      count       <= count_d;
      acc         <= acc_d;
      run_len     <= run_len_d;
      last_chunk  <= last_chunk_d;
      hist        <= hist_d;
      trng_req    <= trng_req_d;
      cli_ack     <= ack_d;
      cli_rdata   <= rdata_d;
      health_fail <= fail_d;
    end
  end

endmodule

// File: doc/trng_arbiter.md
# trng_arbiter

Shares one TRNG word source among N_REQ clients. It arbitrates client requests round-robin and drives the TRNG request/valid handshake. It packs TRNG_WIDTH-bit chunks into 32-bit random words and runs a repetition-count health test on every accepted chunk. It sits between the TRNG core and the per-client MMIO wrappers on the picorv32 SoC bus.

## Interface
- TRNG_WIDTH, 4, chunk width from TRNG. Legal values divide 32. NCHUNK = 32/TRNG_WIDTH.
- N_REQ, 2, number of clients (1..8).
- REP_LIMIT, 8, number of consecutive identical chunks that declares a health failure (2..255).
- clk  in  1  sole clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cli_req  in  N_REQ  level request per client. Held until that client's ack.
- cli_ack  out  N_REQ  one-cycle one-hot pulse. The word on cli_rdata belongs to the acked client.
- cli_rdata  out  32  last delivered word. Held until the next delivery.
- trng_req  out  1  request to TRNG (registered).
- trng_valid  in  1  TRNG chunk valid.
- trng_word  in  TRNG_WIDTH  TRNG chunk.
- health_fail  out  1  sticky health-test failure.
- health_clr  in  1  clears a failure. Acts only in HALT.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, COLLECT, DELIVER, HALT.
- Reset values (asynchronous):
  - state=IDLE, trng_req=0, cli_ack=0, cli_rdata=0, health_fail=0, busy=0.
  - rr pointer=0, chunk count=0, run_len=0, history flag cleared.
- IDLE:
  - If any cli_req bit is set, latch grant = first set index scanning cyclically from rr.
  - Next state COLLECT with trng_req=1 and count=0.
- COLLECT:
  - A chunk is accepted only in a cycle where trng_req && trng_valid. trng_valid while trng_req=0 is ignored.
  - On accept: acc <= {acc[31-TRNG_WIDTH:0], trng_word}, so the first chunk lands in the MSBs. Then count++.
  - trng_req stays high between chunks.
  - On the accept where count==NCHUNK-1: go to DELIVER and drop trng_req.
- DELIVER:
  - cli_ack[grant]=1 and cli_rdata<=acc, both registered, visible this cycle.
  - rr <= (grant+1) mod N_REQ. Next state IDLE.
- Client drop: a client deasserting cli_req mid-collection does not abort the word. The word and ack are still delivered.
- Health test, applied on every accepted chunk:
  - First chunk after reset or clear: run_len=1.
  - Otherwise run_len = (chunk == last_chunk) ? run_len+1 : 1. last_chunk <= chunk.
  - When an accepted chunk makes run_len == REP_LIMIT: next cycle health_fail=1, state=HALT, trng_req=0. The partial word is discarded and no ack is issued.
- HALT:
  - trng_req=0 and cli_ack=0. Client requests remain pending.
  - health_clr=1 clears health_fail, run_len and the history flag. Next state IDLE; pending requests are re-arbitrated from the unchanged rr.
  - health_clr outside HALT has no effect.
- Width rule: run_len saturates at REP_LIMIT and is 8 bits wide.

## Timing
- Request sampled in IDLE at cycle t: trng_req=1 at t+1.
- With trng_valid constantly high, chunks are accepted at t+1..t+NCHUNK and cli_ack pulses at t+NCHUNK+1. That is t+9 for TRNG_WIDTH=4.
- The earliest next request is sampled at t+NCHUNK+2. trng_req is low for at least the DELIVER and IDLE cycles.
- cli_ack is exactly one cycle wide and never has more than one bit set.
- Simultaneous last chunk and health failure: the failure wins. The state goes to HALT and no ack is issued.
- Reset asserted mid-COLLECT: all outputs drop immediately. The partial word and run history are lost.

## Test plan
- Single client, TRNG_WIDTH=4, trng_valid=1, chunks 1,2,...,8 -> cli_ack[0] at t+9, cli_rdata=0x12345678, busy low at t+10.
- Clients 0 and 1 both request continuously -> acks alternate 0,1,0,1. Each word takes 8 distinct chunks.
- trng_valid pulsed every 3rd cycle, plus a valid pulse while trng_req=0 -> the extra pulse is ignored, the word is correct, and the ack lands after the 8th accepted chunk.
- REP_LIMIT=8, chunk 0xA repeated 8 times -> health_fail=1 the cycle after the 8th accept, no ack, trng_req=0. health_clr -> health_fail=0, and the pending request completes with fresh data.
- Same chunk repeated 7 times, then a different chunk, then 7 more of the first -> no failure.
- Reset asserted at the 4th chunk -> all outputs 0 immediately. After release, a new request yields a full 8-chunk word with no residue.
